// File: rtl/move_collector.sv
// move_collector: scans the square array after move generation, filters each square's
// 16 move registers by colour and serialises the survivors as (from, to, kind) records.
// Define MOVE_COLLECTOR_COUNT_EN to build the accepted-move counter; otherwise mv_count is 0.

module move_entry_decode (
    input  logic        color_sel,
    input  logic [11:0] lane,       // {color, kind[4:0], pos[5:0]}
    output logic        hit,
    output logic [10:0] ent         // {kind[4:0], pos[5:0]}
);
    assign hit = (lane[10:6] != 5'd0) && (lane[11] == color_sel);
    assign ent = lane[10:0];
endmodule

module move_collector #(
    parameter int NSQ = 64
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        start,
    input  logic        engineColor,
    output logic [5:0]  sq_sel,
    input  logic [87:0] ray_moves,
    input  logic [63:0] knight_moves,
    output logic        mv_valid,
    input  logic        mv_ready,
    output logic [5:0]  mv_from,
    output logic [5:0]  mv_to,
    output logic [4:0]  mv_kind,
    output logic        busy,
    output logic        done,
    output logic [7:0]  mv_count
);
    localparam int NUM_LANES = 16;
    localparam int NUM_RAY   = 8;
    localparam int ENT_W     = 11;

    typedef enum logic [2:0] {IDLE, SELECT, LOAD, EMIT, DONE} state_t;

    state_t                             state;
    logic                               color;
    logic [NUM_LANES-1:0][11:0]         lane_in;
    logic [NUM_LANES-1:0][ENT_W-1:0]    lane_ent;
    logic [NUM_LANES-1:0][ENT_W-1:0]    snap;
    logic [NUM_LANES-1:0]               lane_hit;
    logic [NUM_LANES-1:0]               pend;
    logic [NUM_LANES-1:0]               rest;
    logic [3:0]                         load_idx;
    logic [3:0]                         rest_idx;
    logic                               last_sq;

    // Ray and knight registers are normalised to one {color, kind, pos} lane format so a
    // single decoder handles both; lane index equals the pending-mask bit.
    genvar g;
    generate
        for (g = 0; g < NUM_RAY; g++) begin : g_ray
            assign lane_in[g] = {ray_moves[11*g+10], 1'b0, ray_moves[11*g +: 10]};
        end
        for (g = 0; g < NUM_RAY; g++) begin : g_knight
            assign lane_in[NUM_RAY+g] = {knight_moves[8*g+7], knight_moves[8*g+6], 4'b0000,
                                         knight_moves[8*g +: 6]};
        end
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            move_entry_decode u_dec (
                .color_sel (color),
                .lane      (lane_in[g]),
                .hit       (lane_hit[g]),
                .ent       (lane_ent[g])
            );
        end
    endgenerate

    function automatic logic [3:0] lowest(input logic [NUM_LANES-1:0] m);
        lowest = 4'd0;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (m[i]) lowest = 4'(i);
    endfunction

    // rest drops the record currently on the bus; its lowest bit is the next record.
    assign rest     = pend & (pend - 1'b1);
    assign rest_idx = lowest(rest);
    assign load_idx = lowest(lane_hit);
    assign last_sq  = (sq_sel == 6'(NSQ - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            color    <= 1'b0;
            sq_sel   <= 6'd0;
            snap     <= '0;
            pend     <= '0;
            mv_valid <= 1'b0;
            mv_from  <= 6'd0;
            mv_to    <= 6'd0;
            mv_kind  <= 5'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        color  <= engineColor;
                        sq_sel <= 6'd0;
                        busy   <= 1'b1;
                        state  <= SELECT;
                    end
                end
                SELECT: state <= LOAD;
                LOAD: begin
                    snap <= lane_ent;
                    pend <= lane_hit;
                    if (|lane_hit) begin
                        mv_valid <= 1'b1;
                        mv_from  <= lane_ent[load_idx][5:0];
                        mv_kind  <= lane_ent[load_idx][10:6];
                        mv_to    <= sq_sel;
                        state    <= EMIT;
                    end else if (last_sq) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        sq_sel <= sq_sel + 6'd1;
                        state  <= SELECT;
                    end
                end
                EMIT: begin
                    if (mv_ready) begin
                        pend <= rest;
                        if (|rest) begin
                            mv_from <= snap[rest_idx][5:0];
                            mv_kind <= snap[rest_idx][10:6];
                        end else begin
                            mv_valid <= 1'b0;
                            if (last_sq) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                sq_sel <= sq_sel + 6'd1;
                                state  <= SELECT;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MOVE_COLLECTOR_COUNT_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            mv_count <= 8'd0;
        else if (state == IDLE && start)
            mv_count <= 8'd0;
        else if (state == EMIT && mv_valid && mv_ready && mv_count != 8'hFF)
            mv_count <= mv_count + 8'd1;
    end
`else
    assign mv_count = 8'd0;
`endif

endmodule
